// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns (g..a order),
// reader FSM states and the decoder result record.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PRESENT,
        ST_WAIT_CHG
    } rd_state_t;

    // Packs as {nib, blank, err}
    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } seg7_dec_t;

    // A single-digit bank still needs a 1-bit index register
    function automatic int seg7_idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    localparam int SEG7_NDIG  = 6;
    localparam int SEG7_IDX_W = seg7_idx_w(SEG7_NDIG);

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex encoder: one active-low pattern to
// {nibble, blank, err}. Blank and unknown patterns both yield nibble 0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output seg7_dec_t  o_dec
);

    always_comb begin
        o_dec = '{nib: 4'h0, blank: 1'b0, err: 1'b0};
        case (i_seg)
            SEG_0:     o_dec.nib = 4'h0;
            SEG_1:     o_dec.nib = 4'h1;
            SEG_2:     o_dec.nib = 4'h2;
            SEG_3:     o_dec.nib = 4'h3;
            SEG_4:     o_dec.nib = 4'h4;
            SEG_5:     o_dec.nib = 4'h5;
            SEG_6:     o_dec.nib = 4'h6;
            SEG_7:     o_dec.nib = 4'h7;
            SEG_8:     o_dec.nib = 4'h8;
            SEG_9:     o_dec.nib = 4'h9;
            SEG_A:     o_dec.nib = 4'hA;
            SEG_B:     o_dec.nib = 4'hB;
            SEG_C:     o_dec.nib = 4'hC;
            SEG_D:     o_dec.nib = 4'hD;
            SEG_E:     o_dec.nib = 4'hE;
            SEG_F:     o_dec.nib = 4'hF;
            SEG_BLANK: o_dec.blank = 1'b1;
            default:   o_dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Watches a seven-segment bank until it holds steady, then decodes it one
// digit per cycle through a shared decoder and offers the word on valid/ready.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NDIG          = SEG7_NDIG,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NDIG*7-1:0]   seg_in,
    output logic [NDIG*4-1:0]   value,
    output logic [NDIG-1:0]     err_mask,
    output logic [NDIG-1:0]     blank_mask,
    output logic                valid,
    input  logic                ready
);

    localparam int            IW       = seg7_idx_w(NDIG);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
    // Match count that, with one more match, completes the stable run
    localparam logic [7:0]    CAP_CNT  = 8'(STABLE_CYCLES - 2);

    rd_state_t          r_state;
    logic [NDIG*7-1:0]  r_prev;
    logic [NDIG*7-1:0]  r_snap;
    logic [7:0]         r_cnt;
    logic               r_primed;
    logic [IW-1:0]      r_idx;
    logic [NDIG*4-1:0]  r_value;
    logic [NDIG-1:0]    r_err;
    logic [NDIG-1:0]    r_blank;
    logic               r_valid;

    logic [6:0]         w_seg_sel;
    seg7_dec_t          w_dec;
    logic               w_same;

    assign w_seg_sel = r_snap[7*int'(r_idx) +: 7];
    assign w_same    = (seg_in == r_prev);

    seg7_decode u_dec (
        .i_seg (w_seg_sel),
        .o_dec (w_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_prev   <= '1;
            r_snap   <= '1;
            r_cnt    <= '0;
            r_primed <= 1'b0;
            r_idx    <= '0;
            r_value  <= '0;
            r_err    <= '0;
            r_blank  <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_prev   <= seg_in;
                    r_primed <= 1'b1;
                    // The first sample of a run has nothing valid to match against
                    if (!r_primed || !w_same) begin
                        r_cnt <= '0;
                    end else begin
                        if (r_cnt != 8'hFF)
                            r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == CAP_CNT) begin
                            r_snap  <= seg_in;
                            r_idx   <= '0;
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    r_value[4*int'(r_idx) +: 4] <= w_dec.nib;
                    r_err[r_idx]                <= w_dec.err;
                    r_blank[r_idx]              <= w_dec.blank;
                    if (r_idx == LAST_IDX) begin
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_WAIT_CHG;
                    end
                end
                ST_WAIT_CHG: begin
                    // Re-arm only once the display moves off the reported snapshot
                    if (seg_in != r_snap) begin
                        r_cnt    <= '0;
                        r_primed <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign value      = r_value;
    assign err_mask   = r_err;
    assign blank_mask = r_blank;
    assign valid      = r_valid;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: expected words are queued as patterns are
// driven and popped when the DUT completes a valid/ready transfer.
module tb_seg7_reader;

    localparam int NDIG = 6;

    typedef struct packed {
        logic [23:0] v;
        logic [5:0]  e;
        logic [5:0]  b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [41:0] seg_in = '1;
    logic [23:0] value;
    logic [5:0]  err_mask;
    logic [5:0]  blank_mask;
    logic        valid;
    logic        ready = 1'b1;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   n_xfer = 0;

    always #5 clk = ~clk;

    seg7_reader #(.NDIG(NDIG), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .value      (value),
        .err_mask   (err_mask),
        .blank_mask (blank_mask),
        .valid      (valid),
        .ready      (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [41:0] enc_word(input logic [23:0] w);
        logic [41:0] r;
        for (int i = 0; i < NDIG; i++) r[7*i +: 7] = enc(w[4*i +: 4]);
        return r;
    endfunction

    // Transfer monitor: a handshake happens at the next rising edge
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("value", {8'h0, value}, {8'h0, e.v});
                chk("err_mask", {26'h0, err_mask}, {26'h0, e.e});
                chk("blank_mask", {26'h0, blank_mask}, {26'h0, e.b});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges until valid is seen; a timeout shows up as a wrong count
    task automatic wait_valid(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!valid && n < 40);
        chk(tag, n, exp_n);
    endtask

    task automatic wait_xfer(input string tag, input int target);
        int n;
        n = 0;
        while (n_xfer < target && n < 60) begin
            step(1);
            n++;
        end
        chk(tag, n_xfer, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] w;
        logic [41:0] p;
        logic [23:0] rw;
        logic [23:0] last;
        int          bad;

        // Reset state
        ready  = 1'b1;
        seg_in = enc_word(24'h1E2A3F);
        rst_n  = 1'b0;
        step(2);
        chk("rst_value", {8'h0, value}, 32'h0);
        chk("rst_err", {26'h0, err_mask}, 32'h0);
        chk("rst_blank", {26'h0, blank_mask}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);

        // Key display: valid after edge 10, single-cycle pulse, no repeat
        sb_q.push_back(exp_t'{v: 24'h1E2A3F, e: 6'h0, b: 6'h0});
        rst_n = 1'b1;
        wait_valid("lat_key", 10);
        step(1);
        chk("pulse_one_cycle", {31'h0, valid}, 32'h0);
        step(20);
        chk("no_repeat", n_xfer, 1);

        // Unrecognised pattern on digit 2; re-arm spacing is 11 edges
        w = enc_word(24'h0);
        w[20:14] = 7'b1111110;
        sb_q.push_back(exp_t'{v: 24'h0, e: 6'b000100, b: 6'h0});
        seg_in = w;
        wait_valid("lat_rearm", 11);
        wait_xfer("xfer_err", 2);

        // All digits blank
        sb_q.push_back(exp_t'{v: 24'h0, e: 6'h0, b: 6'h3F});
        seg_in = '1;
        wait_valid("lat_blank", 11);
        wait_xfer("xfer_blank", 3);

        // Glitch on digit 0 restarts the stability count
        p = enc_word(24'h123456);
        sb_q.push_back(exp_t'{v: 24'h123456, e: 6'h0, b: 6'h0});
        seg_in = p;
        step(3);
        w = p;
        w[6:0] = enc(4'h7);
        seg_in = w;
        step(1);
        seg_in = p;
        wait_valid("lat_glitch", 10);
        wait_xfer("xfer_glitch", 4);

        // Backpressure: output frozen while ready is low, new pattern follows
        ready = 1'b0;
        sb_q.push_back(exp_t'{v: 24'h9ABCDE, e: 6'h0, b: 6'h0});
        seg_in = enc_word(24'h9ABCDE);
        wait_valid("lat_bp", 11);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                sb_q.push_back(exp_t'{v: 24'h0F0F07, e: 6'h0, b: 6'h0});
                seg_in = enc_word(24'h0F0F07);
            end
            step(1);
            if (!valid || value !== 24'h9ABCDE) bad++;
        end
        chk("bp_hold", bad, 0);
        ready = 1'b1;
        step(1);
        chk("bp_drop", {31'h0, valid}, 32'h0);
        chk("bp_accept", n_xfer, 5);
        wait_valid("lat_bp_new", 11);
        wait_xfer("xfer_bp_new", 6);

        // Reset asserted on the third SCAN edge discards the partial result
        seg_in = enc_word(24'h2468AC);
        step(7);
        chk("scan_partial", {24'h0, value[7:0]}, 32'hAC);
        rst_n = 1'b0;
        step(1);
        chk("rst2_value", {8'h0, value}, 32'h0);
        chk("rst2_err", {26'h0, err_mask}, 32'h0);
        chk("rst2_blank", {26'h0, blank_mask}, 32'h0);
        chk("rst2_valid", {31'h0, valid}, 32'h0);
        rst_n = 1'b1;
        sb_q.push_back(exp_t'{v: 24'h2468AC, e: 6'h0, b: 6'h0});
        wait_valid("lat_post_rst", 10);
        wait_xfer("xfer_post_rst", 7);

        // A few random hex words
        last = 24'h2468AC;
        for (int k = 0; k < 3; k++) begin
            rw = 24'($urandom);
            if (rw == last) rw = rw ^ 24'h1;
            last = rw;
            sb_q.push_back(exp_t'{v: rw, e: 6'h0, b: 6'h0});
            seg_in = enc_word(rw);
            wait_valid("lat_rand", 11);
            wait_xfer("xfer_rand", 8 + k);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
